prbs_rx_chk: RTL and testbench
==============================

Name: prbs_rx_chk

Overview:
- Receive-end checker for the 48-bit PRBS stream emitted by the DCFEB/TMB link PRBS generator.
- Detects the start pattern and aligns a local copy of the 24-bit LFSR ([24,23,22,17] Fibonacci, fill 24'h83B62E) to the incoming stream.
- Once aligned, compares every received word against the expected word and reports lock, per-word error pulses, and saturating bit/word error counters.
- Sits behind the link deserializer in the same word-strobed clock domain (GEN_CLK with a word enable).

Parameters:
start_pattern, 48'hFFFFFF000000, word the transmitter sends while in reset
init_fill, 24'h83B62E, LFSR state S(0) after the start pattern
MAX_ERR, 4, consecutive errored words in CHECK that force loss of lock (1..15)
CNT_W, 32, width of the error and word counters

Ports:
GEN_CLK  in  1  link word clock
RST_N  in  1  asynchronous, active-low reset
IN_CLK_ENA  in  1  word strobe; RX_DATA is valid and all state advances only when high
RX_DATA  in  48  received word
CLR_ERR  in  1  synchronous clear of counters and SYNC_LOST; takes effect regardless of IN_CLK_ENA
LOCKED  out  1  high while in CHECK
ERR_WORD  out  1  one-GEN_CLK pulse, registered, for a checked word with mismatch
SYNC_LOST  out  1  sticky; set on CHECK->HUNT due to MAX_ERR
BIT_ERR_CNT  out  CNT_W  total mismatched bits, saturating
WORD_ERR_CNT  out  CNT_W  total mismatched words, saturating
WORD_CNT  out  CNT_W  total words checked in CHECK, saturating

Behaviour:
- Reset (RST_N low, asynchronous):
  - State = HUNT; all outputs 0.
  - Local LFSR = init_fill.
  - Consecutive-error counter = 0.
- Expected stream: word k after the last start-pattern word = {S(2k+1), S(2k)}.
  - S(0) = init_fill.
  - S(n+1) = {S(n)[22:0], S(n)[23]^S(n)[22]^S(n)[21]^S(n)[16]}.
  - The checker advances its LFSR by exactly two steps per checked word.
- States (transitions evaluated only when IN_CLK_ENA = 1):
  - HUNT:
    - RX_DATA == start_pattern -> START.
    - Otherwise stay; no checking, no counting.
  - START:
    - LFSR held at init_fill.
    - RX_DATA == start_pattern -> stay.
    - Any other word is checked as word 0 against {S(1), S(0)} and LFSR advances.
    - Match -> CHECK.
    - Mismatch -> HUNT; counters are not updated.
  - CHECK (LOCKED = 1):
    - Every word is compared against the expected word.
    - Mismatch: ERR_WORD pulses on the next clock; BIT_ERR_CNT += popcount(XOR) (0..48, 6-bit adder); WORD_ERR_CNT += 1; consecutive counter += 1.
    - Match: consecutive counter cleared.
    - WORD_CNT += 1 per checked word.
    - RX_DATA == start_pattern -> START (transmitter re-reset). That word is not counted as an error.
    - Consecutive counter reaching MAX_ERR -> HUNT and SYNC_LOST set.
- Latency: LOCKED and ERR_WORD assert one GEN_CLK after the strobed word; counters update on the same edge.
- Saturation: each counter holds at all-ones; it never wraps.
- CLR_ERR:
  - Clears the counters and SYNC_LOST on the next edge.
  - Does not alter the state or the LFSR.
  - If a counted word arrives on the same edge, the clear wins and that word is dropped from the counts.
- IN_CLK_ENA low: all state and the LFSR hold; ERR_WORD is 0.
- RST_N asserted mid-operation: immediate return to reset values.

Optional Feature:
PRBS_RX_LTNCY_EN
- Defined: adds ports STRT_LTNCY_IN (in, 1), LTNCY (out, 16), LTNCY_VLD (out, 1).
  - A rising edge of STRT_LTNCY_IN starts a counter of IN_CLK_ENA words, and LTNCY_VLD clears at the same time.
  - The count stops at the START->CHECK transition; LTNCY then holds the count and LTNCY_VLD = 1.
  - The counter saturates at 16'hFFFF.
  - Reset clears LTNCY and LTNCY_VLD.
- Undefined: none of these ports or this logic exist.

Decomposition:
- Shared package: state enum (HUNT, START, CHECK), PRBS_START_PATTERN, LFSR_INIT_FILL, tap constant, injected-error mask 48'h608000400100 (for benches).
- One sub-module, prbs_lfsr24_step2: combinational two-step advance of the 24-bit LFSR, returning both S(n+1) and S(n+2). It is reusable by the generator side.

Test Plan:
1. Reset, then 3 start-pattern words followed by a clean stream of 100 words -> LOCKED = 1 one clock after word 0; WORD_CNT = 100; both error counters = 0.
2. Locked stream with word 10 XORed with 48'h608000400100 -> a single ERR_WORD pulse; BIT_ERR_CNT = 5; WORD_ERR_CNT = 1; LOCKED stays 1.
3. Locked stream followed by 4 consecutive all-zero words -> the 4th forces LOCKED = 0 and SYNC_LOST = 1; WORD_ERR_CNT = 4; then CLR_ERR -> all counters and SYNC_LOST = 0.
4. While locked, 2 start-pattern words then a clean restart -> START entered without errors; relock on the new word 0; counters unchanged except WORD_CNT.
5. IN_CLK_ENA toggling 1-0-1 with garbage RX_DATA on the low cycles -> no errors; result identical to the continuous-strobe case.
6. With PRBS_RX_LTNCY_EN defined: pulse STRT_LTNCY_IN, then 7 strobed words before a valid word 0 -> LTNCY = 7 and LTNCY_VLD = 1.

Source files
------------

// File: rtl/prbs_rx_chk_pkg.sv
// Shared definitions for the PRBS receive checker: FSM states, stream
// constants and the 24-bit Fibonacci LFSR step ([24,23,22,17] taps).
// Optional latency measurement in prbs_rx_chk is enabled by PRBS_RX_LTNCY_EN.
package prbs_rx_chk_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        START = 2'd1,
        CHECK = 2'd2
    } state_e;

    localparam logic [47:0] PRBS_START_PATTERN = 48'hFFFFFF000000;
    localparam logic [23:0] LFSR_INIT_FILL     = 24'h83B62E;
    // Feedback taps: bits 23, 22, 21 and 16 of the current state
    localparam logic [23:0] LFSR_TAPS          = 24'hE10000;
    // Error mask used by benches to corrupt a single word (5 bits set)
    localparam logic [47:0] PRBS_ERR_MASK      = 48'h608000400100;

    // One LFSR step: shift left, feed back the XOR of the tapped bits
    function automatic logic [23:0] lfsr_step(input logic [23:0] s);
        return {s[22:0], ^(s & LFSR_TAPS)};
    endfunction

    // Number of set bits in a 48-bit word (0..48)
    function automatic logic [5:0] popcount48(input logic [47:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 48; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/prbs_lfsr24_step2.sv
// Combinational two-step advance of the 24-bit PRBS LFSR.
// Returns S(n+1) and S(n+2) for S(n) = lfsr_in; one 48-bit word is
// {S(n+1), S(n)}, and S(n+2) is the state for the following word.
module prbs_lfsr24_step2
    import prbs_rx_chk_pkg::*;
(
    input  logic [23:0] lfsr_in,
    output logic [23:0] lfsr_s1,
    output logic [23:0] lfsr_s2
);

    // Two chained steps of the feedback shift
    always_comb begin
        lfsr_s1 = lfsr_step(lfsr_in);
        lfsr_s2 = lfsr_step(lfsr_s1);
    end

endmodule

// File: rtl/prbs_rx_chk.sv
// PRBS receive checker: hunts for the start pattern, aligns a local LFSR
// to the incoming 48-bit stream, then checks every strobed word and keeps
// saturating bit/word error counters.
// Define PRBS_RX_LTNCY_EN to add the start-to-lock latency measurement.
module prbs_rx_chk
    import prbs_rx_chk_pkg::*;
#(
    parameter int MAX_ERR = 4,
    parameter int CNT_W   = 32
)
(
    input  logic             GEN_CLK,
    input  logic             RST_N,
    input  logic             IN_CLK_ENA,
    input  logic [47:0]      RX_DATA,
    input  logic             CLR_ERR,
`ifdef PRBS_RX_LTNCY_EN
    input  logic             STRT_LTNCY_IN,
    output logic [15:0]      LTNCY,
    output logic             LTNCY_VLD,
`endif
    output logic             LOCKED,
    output logic             ERR_WORD,
    output logic             SYNC_LOST,
    output logic [CNT_W-1:0] BIT_ERR_CNT,
    output logic [CNT_W-1:0] WORD_ERR_CNT,
    output logic [CNT_W-1:0] WORD_CNT
);

    localparam logic [3:0] MAX_ERR_L = 4'(MAX_ERR);

    state_e           state_q, state_d;
    logic [23:0]      lfsr_q, lfsr_d;
    logic [3:0]       consec_q, consec_d;
    logic             err_word_q, err_word_d;
    logic             sync_lost_q, sync_lost_d;
    logic [CNT_W-1:0] bit_err_cnt_q, bit_err_cnt_d;
    logic [CNT_W-1:0] word_err_cnt_q, word_err_cnt_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

    logic [23:0]      lfsr_s1, lfsr_s2;
    logic [47:0]      exp_word, diff;
    logic             is_start, mismatch, word_chk, word_err;
    logic [5:0]       bit_pop;
    logic [3:0]       consec_inc;
    logic [CNT_W:0]   bit_sum, werr_sum, wcnt_sum;

    prbs_lfsr24_step2 u_step (
        .lfsr_in (lfsr_q),
        .lfsr_s1 (lfsr_s1),
        .lfsr_s2 (lfsr_s2)
    );

    // FSM next state, LFSR advance and saturating counter updates
    always_comb begin
        state_d        = state_q;
        lfsr_d         = lfsr_q;
        consec_d       = consec_q;
        err_word_d     = 1'b0;
        sync_lost_d    = sync_lost_q;
        word_chk       = 1'b0;
        word_err       = 1'b0;
        exp_word       = {lfsr_s1, lfsr_q};
        diff           = RX_DATA ^ exp_word;
        mismatch       = |diff;
        is_start       = (RX_DATA == PRBS_START_PATTERN);
        consec_inc     = consec_q + 4'd1;

        if (IN_CLK_ENA) begin
            case (state_q)
                HUNT: begin
                    if (is_start) begin
                        state_d  = START;
                        lfsr_d   = LFSR_INIT_FILL;
                        consec_d = 4'd0;
                    end
                end
                START: begin
                    if (is_start) begin
                        lfsr_d = LFSR_INIT_FILL;
                    end else if (!mismatch) begin
                        // Word 0 matched: it is the first counted word
                        state_d  = CHECK;
                        lfsr_d   = lfsr_s2;
                        word_chk = 1'b1;
                    end else begin
                        // Failed alignment is silent: back to hunting
                        state_d = HUNT;
                        lfsr_d  = LFSR_INIT_FILL;
                    end
                end
                CHECK: begin
                    if (is_start) begin
                        // Transmitter re-reset: realign without counting
                        state_d  = START;
                        lfsr_d   = LFSR_INIT_FILL;
                        consec_d = 4'd0;
                    end else begin
                        lfsr_d   = lfsr_s2;
                        word_chk = 1'b1;
                        if (mismatch) begin
                            word_err   = 1'b1;
                            err_word_d = 1'b1;
                            if (consec_inc >= MAX_ERR_L) begin
                                state_d     = HUNT;
                                consec_d    = 4'd0;
                                sync_lost_d = 1'b1;
                            end else begin
                                consec_d = consec_inc;
                            end
                        end else begin
                            consec_d = 4'd0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        bit_pop  = word_err ? popcount48(diff) : 6'd0;
        bit_sum  = {1'b0, bit_err_cnt_q}  + {{(CNT_W-5){1'b0}}, bit_pop};
        werr_sum = {1'b0, word_err_cnt_q} + {{CNT_W{1'b0}}, word_err};
        wcnt_sum = {1'b0, word_cnt_q}     + {{CNT_W{1'b0}}, word_chk};

        bit_err_cnt_d  = bit_sum[CNT_W]  ? '1 : bit_sum[CNT_W-1:0];
        word_err_cnt_d = werr_sum[CNT_W] ? '1 : werr_sum[CNT_W-1:0];
        word_cnt_d     = wcnt_sum[CNT_W] ? '1 : wcnt_sum[CNT_W-1:0];

        // Clear beats any same-edge count; FSM and LFSR are untouched
        if (CLR_ERR) begin
            bit_err_cnt_d  = '0;
            word_err_cnt_d = '0;
            word_cnt_d     = '0;
            sync_lost_d    = 1'b0;
        end
    end

    // State, LFSR, error pulse and counter registers
    always_ff @(posedge GEN_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q        <= HUNT;
            lfsr_q         <= LFSR_INIT_FILL;
            consec_q       <= 4'd0;
            err_word_q     <= 1'b0;
            sync_lost_q    <= 1'b0;
            bit_err_cnt_q  <= '0;
            word_err_cnt_q <= '0;
            word_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            consec_q       <= consec_d;
            err_word_q     <= err_word_d;
            sync_lost_q    <= sync_lost_d;
            bit_err_cnt_q  <= bit_err_cnt_d;
            word_err_cnt_q <= word_err_cnt_d;
            word_cnt_q     <= word_cnt_d;
        end
    end

    assign LOCKED       = (state_q == CHECK);
    assign ERR_WORD     = err_word_q;
    assign SYNC_LOST    = sync_lost_q;
    assign BIT_ERR_CNT  = bit_err_cnt_q;
    assign WORD_ERR_CNT = word_err_cnt_q;
    assign WORD_CNT     = word_cnt_q;

`ifdef PRBS_RX_LTNCY_EN
    logic        strt_prev_q, strt_prev_d;
    logic [15:0] ltncy_q, ltncy_d;
    logic        ltncy_vld_q, ltncy_vld_d;
    logic        ltncy_run_q, ltncy_run_d;
    logic        lock_evt;

    assign lock_evt = IN_CLK_ENA && (state_q == START) && (state_d == CHECK);

    // Count strobed words from a start request until the next lock
    always_comb begin
        strt_prev_d = STRT_LTNCY_IN;
        ltncy_d     = ltncy_q;
        ltncy_vld_d = ltncy_vld_q;
        ltncy_run_d = ltncy_run_q;
        if (STRT_LTNCY_IN && !strt_prev_q) begin
            ltncy_d     = 16'd0;
            ltncy_vld_d = 1'b0;
            ltncy_run_d = 1'b1;
        end else if (ltncy_run_q && IN_CLK_ENA) begin
            if (lock_evt) begin
                ltncy_run_d = 1'b0;
                ltncy_vld_d = 1'b1;
            end else if (ltncy_q != 16'hFFFF) begin
                ltncy_d = ltncy_q + 16'd1;
            end
        end
    end

    // Latency measurement registers
    always_ff @(posedge GEN_CLK or negedge RST_N) begin
        if (!RST_N) begin
            strt_prev_q <= 1'b0;
            ltncy_q     <= 16'd0;
            ltncy_vld_q <= 1'b0;
            ltncy_run_q <= 1'b0;
        end else begin
            strt_prev_q <= strt_prev_d;
            ltncy_q     <= ltncy_d;
            ltncy_vld_q <= ltncy_vld_d;
            ltncy_run_q <= ltncy_run_d;
        end
    end

    assign LTNCY     = ltncy_q;
    assign LTNCY_VLD = ltncy_vld_q;
`endif

endmodule

// File: tb/tb_prbs_rx_chk.sv
// Directed-plus-random bench for prbs_rx_chk. The transmitted stream is
// rebuilt from the LFSR recurrence into a table; expected counters are
// tracked from the scenario being driven.
module tb_prbs_rx_chk;

    localparam logic [47:0] START_PAT = 48'hFFFFFF000000;
    localparam logic [23:0] FILL      = 24'h83B62E;
    localparam logic [47:0] ERR_MASK  = 48'h608000400100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [47:0] rx_data;
    logic        clr_err;
    logic        locked, err_word, sync_lost;
    logic [31:0] bit_err_cnt, word_err_cnt, word_cnt;
`ifdef PRBS_RX_LTNCY_EN
    logic        strt_ltncy;
    logic [15:0] ltncy;
    logic        ltncy_vld;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic [23:0] s_seq [0:2047];
    int          tx_k;
    logic [31:0] exp_wc, exp_werr, exp_bit;

    prbs_rx_chk dut (
        .GEN_CLK      (clk),
        .RST_N        (rst_n),
        .IN_CLK_ENA   (ena),
        .RX_DATA      (rx_data),
        .CLR_ERR      (clr_err),
`ifdef PRBS_RX_LTNCY_EN
        .STRT_LTNCY_IN(strt_ltncy),
        .LTNCY        (ltncy),
        .LTNCY_VLD    (ltncy_vld),
`endif
        .LOCKED       (locked),
        .ERR_WORD     (err_word),
        .SYNC_LOST    (sync_lost),
        .BIT_ERR_CNT  (bit_err_cnt),
        .WORD_ERR_CNT (word_err_cnt),
        .WORD_CNT     (word_cnt)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] tx_word(input int k);
        return {s_seq[2*k+1], s_seq[2*k]};
    endfunction

    task automatic strobe(input logic [47:0] d, input logic clr);
        @(negedge clk);
        rx_data = d;
        ena     = 1'b1;
        clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic clr);
        @(negedge clk);
        rx_data = 48'({$urandom(), $urandom()});
        ena     = 1'b0;
        clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic send_clean(input int n);
        for (int i = 0; i < n; i++) begin
            strobe(tx_word(tx_k), 1'b0);
            tx_k++;
            exp_wc++;
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_wcnt"}, word_cnt, exp_wc);
        check({tag, "_werr"}, word_err_cnt, exp_werr);
        check({tag, "_bit"}, bit_err_cnt, exp_bit);
    endtask

    initial begin
        logic [47:0] mask;
        logic [47:0] w;

        // Reference stream from S(n+1) = {S[22:0], S23^S22^S21^S16}
        s_seq[0] = FILL;
        for (int n = 1; n < 2048; n++) begin
            w[23:0]  = s_seq[n-1];
            s_seq[n] = {w[22:0], w[23] ^ w[22] ^ w[21] ^ w[16]};
        end

        rst_n   = 1'b0;
        ena     = 1'b0;
        clr_err = 1'b0;
        rx_data = 48'd0;
`ifdef PRBS_RX_LTNCY_EN
        strt_ltncy = 1'b0;
`endif
        exp_wc = 0; exp_werr = 0; exp_bit = 0;

        // Reset state
        #12;
        check("rst_locked", locked, 1'b0);
        check("rst_err_word", err_word, 1'b0);
        check("rst_sync_lost", sync_lost, 1'b0);
        check_counts("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Clean lock: 3 start words then 100 stream words
        for (int i = 0; i < 3; i++) begin
            strobe(START_PAT, 1'b0);
            check("t1_start_unlocked", locked, 1'b0);
        end
        tx_k = 0;
        send_clean(1);
        check("t1_lock_after_w0", locked, 1'b1);
        send_clean(99);
        check("t1_locked", locked, 1'b1);
        check("t1_err_word", err_word, 1'b0);
        check("t1_sync_lost", sync_lost, 1'b0);
        check_counts("t1");

        // Single corrupted word with the 5-bit mask
        send_clean(10);
        strobe(tx_word(tx_k) ^ ERR_MASK, 1'b0);
        tx_k++; exp_wc++; exp_werr++; exp_bit += 5;
        check("t2_err_pulse", err_word, 1'b1);
        check("t2_locked", locked, 1'b1);
        check_counts("t2");
        send_clean(1);
        check("t2_pulse_end", err_word, 1'b0);

        // Random isolated errors
        for (int r = 0; r < 8; r++) begin
            send_clean(int'($urandom_range(1, 4)));
            mask = 48'({$urandom(), $urandom()});
            if (mask == 48'd0) mask = 48'd1;
            strobe(tx_word(tx_k) ^ mask, 1'b0);
            tx_k++; exp_wc++; exp_werr++;
            exp_bit += 32'($countones(mask));
            check("rnd_err_pulse", err_word, 1'b1);
            check("rnd_locked", locked, 1'b1);
            check_counts("rnd");
        end

        // Strobe toggling with garbage on idle cycles
        for (int i = 0; i < 20; i++) begin
            send_clean(1);
            check("t5_strobe_err", err_word, 1'b0);
            idle(1'b0);
            check("t5_idle_err", err_word, 1'b0);
            check("t5_idle_wcnt", word_cnt, exp_wc);
            check("t5_idle_locked", locked, 1'b1);
        end
        check_counts("t5");

        // Transmitter re-reset while locked
        strobe(START_PAT, 1'b0);
        check("t4_start1_unlocked", locked, 1'b0);
        check("t4_start1_err", err_word, 1'b0);
        strobe(START_PAT, 1'b0);
        check_counts("t4_start");
        tx_k = 0;
        send_clean(1);
        check("t4_relock", locked, 1'b1);
        send_clean(9);
        check_counts("t4");

        // Four consecutive zero words force loss of lock
        for (int i = 0; i < 4; i++) begin
            w = tx_word(tx_k);
            tx_k++;
            strobe(48'd0, 1'b0);
            exp_wc++; exp_werr++;
            exp_bit += 32'($countones(w));
            check("t3_err_pulse", err_word, 1'b1);
            check("t3_locked", locked, (i < 3) ? 1'b1 : 1'b0);
            check("t3_sync_lost", sync_lost, (i < 3) ? 1'b0 : 1'b1);
        end
        check_counts("t3");
        send_clean(3);
        exp_wc -= 3;
        check("t3_hunt_locked", locked, 1'b0);
        check_counts("t3_hunt");
        idle(1'b1);
        exp_wc = 0; exp_werr = 0; exp_bit = 0;
        check("t3_clr_sync", sync_lost, 1'b0);
        check_counts("t3_clr");

        // Clear on the same edge as the first counted word
        strobe(START_PAT, 1'b0);
        tx_k = 0;
        strobe(tx_word(tx_k), 1'b1);
        tx_k++;
        check("clr_win_locked", locked, 1'b1);
        check("clr_win_wcnt", word_cnt, 32'd0);
        send_clean(5);
        check("clr_win_after", word_cnt, exp_wc);

        // Asynchronous reset mid-operation
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_locked", locked, 1'b0);
        check("arst_wcnt", word_cnt, 32'd0);
        exp_wc = 0; exp_werr = 0; exp_bit = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b0);
        strobe(START_PAT, 1'b0);
        tx_k = 0;
        send_clean(1);
        check("arst_relock", locked, 1'b1);
        check_counts("arst");

`ifdef PRBS_RX_LTNCY_EN
        // Latency: request, then 7 strobed words before word 0
        @(negedge clk);
        strt_ltncy = 1'b1;
        ena        = 1'b0;
        @(posedge clk);
        #1;
        check("lat_vld_cleared", ltncy_vld, 1'b0);
        @(negedge clk);
        strt_ltncy = 1'b0;
        for (int i = 0; i < 7; i++) strobe(START_PAT, 1'b0);
        tx_k = 0;
        send_clean(1);
        check("lat_value", ltncy, 16'd7);
        check("lat_vld", ltncy_vld, 1'b1);
`endif

        idle(1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
